// File: rtl/pipe_hazard_ctrl_pkg.sv
// pipe_ctrl_pkg: shared state encoding and constants for the pipeline hazard controller
package pipe_ctrl_pkg;
  typedef enum logic [1:0] {RUN = 2'd0, LSTALL = 2'd1, FREEZE = 2'd2} state_t;
  localparam int REG_ZERO = 0;
  localparam int DEF_CNT_W = 16;
endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// pipe_hazard_ctrl_if: pipeline status inputs and hold/flush/bubble controls of the hazard controller
interface pipe_hazard_ctrl_if import pipe_ctrl_pkg::*; #(
  parameter int REG_AW = 5,
  parameter int CNT_W = DEF_CNT_W
);
  logic id_valid;
  logic [REG_AW-1:0] id_rs;
  logic [REG_AW-1:0] id_rt;
  logic id_uses_rs;
  logic id_uses_rt;
  logic id_jump;
  logic ex_valid;
  logic [REG_AW-1:0] ex_rd;
  logic ex_mem_read;
  logic branch_taken;
  logic mem_busy;
  logic hazard;
  logic ifid_hold;
  logic ifid_flush;
  logic idex_bubble;
  logic idex_hold;
  logic exmem_hold;
  logic [CNT_W-1:0] stall_cycles;
  logic [CNT_W-1:0] flush_count;
  modport master (
    output id_valid, id_rs, id_rt, id_uses_rs, id_uses_rt, id_jump,
    output ex_valid, ex_rd, ex_mem_read, branch_taken, mem_busy,
    input hazard, ifid_hold, ifid_flush, idex_bubble, idex_hold, exmem_hold,
    input stall_cycles, flush_count
  );
  modport slave (
    input id_valid, id_rs, id_rt, id_uses_rs, id_uses_rt, id_jump,
    input ex_valid, ex_rd, ex_mem_read, branch_taken, mem_busy,
    output hazard, ifid_hold, ifid_flush, idex_bubble, idex_hold, exmem_hold,
    output stall_cycles, flush_count
  );
endinterface

// File: rtl/pipe_hazard_ctrl_raw_detect.sv
// raw_detect: combinational load-use RAW comparator between the ID sources and the EX load destination
module raw_detect import pipe_ctrl_pkg::*; #(
  parameter int REG_AW = 5
) (
  input  logic              id_valid,
  input  logic [REG_AW-1:0] id_rs,
  input  logic [REG_AW-1:0] id_rt,
  input  logic              id_uses_rs,
  input  logic              id_uses_rt,
  input  logic              ex_valid,
  input  logic [REG_AW-1:0] ex_rd,
  input  logic              ex_mem_read,
  output logic              lu
);
  assign lu = ex_valid & ex_mem_read & (ex_rd != REG_AW'(REG_ZERO)) & id_valid &
              ((id_uses_rs & (id_rs == ex_rd)) | (id_uses_rt & (id_rt == ex_rd)));
endmodule

// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: load-use / branch / jump / memory-wait sequencing with saturating perf counters
module pipe_hazard_ctrl import pipe_ctrl_pkg::*; #(
  parameter int REG_AW = 5,
  parameter int LOAD_LAT = 1,
  parameter int CNT_W = DEF_CNT_W
) (
  input logic clk,
  input logic rst,
  pipe_hazard_ctrl_if.slave bus
);
  state_t state, state_nx, ret_state, ret_nx, eff;
  logic [3:0] cnt, cnt_nx;
  logic lu, frz, br, ls, jp, haz, fl;
  logic [CNT_W-1:0] stall_q, flush_q;
  raw_detect #(.REG_AW(REG_AW)) u_raw (
    .id_valid(bus.id_valid), .id_rs(bus.id_rs), .id_rt(bus.id_rt),
    .id_uses_rs(bus.id_uses_rs), .id_uses_rt(bus.id_uses_rt),
    .ex_valid(bus.ex_valid), .ex_rd(bus.ex_rd), .ex_mem_read(bus.ex_mem_read), .lu(lu)
  );
  // a freeze is transparent: once released, the cycle behaves as the saved state
  assign eff = state == FREEZE ? ret_state : state;
  always_comb begin
    state_nx = eff;
    ret_nx = ret_state;
    cnt_nx = cnt;
    frz = 1'b0;
    br = 1'b0;
    ls = 1'b0;
    jp = 1'b0;
    if (bus.mem_busy) begin
      frz = 1'b1;
      state_nx = FREEZE;
      ret_nx = eff;
    end else if (bus.branch_taken) begin
      br = 1'b1;
      state_nx = RUN;
      cnt_nx = '0;
    end else if (eff == LSTALL) begin
      ls = 1'b1;
      cnt_nx = cnt - 4'd1;
      state_nx = cnt == 4'd1 ? RUN : LSTALL;
    end else if (lu) begin
      ls = 1'b1;
      cnt_nx = 4'(LOAD_LAT - 1);
      state_nx = LOAD_LAT > 1 ? LSTALL : RUN;
    end else begin
      jp = bus.id_jump;
    end
  end
  assign haz = rst & (frz | ls);
  assign fl = rst & (br | jp);
  assign bus.hazard = haz;
  assign bus.ifid_hold = haz;
  assign bus.ifid_flush = fl;
  assign bus.idex_bubble = rst & (br | ls);
  assign bus.idex_hold = rst & frz;
  assign bus.exmem_hold = rst & frz;
  assign bus.stall_cycles = stall_q;
  assign bus.flush_count = flush_q;
  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= RUN;
      ret_state <= RUN;
      cnt <= '0;
      stall_q <= '0;
      flush_q <= '0;
    end else begin
      state <= state_nx;
      ret_state <= ret_nx;
      cnt <= cnt_nx;
      stall_q <= (haz && !(&stall_q)) ? stall_q + CNT_W'(1) : stall_q;
      flush_q <= (fl && !(&flush_q)) ? flush_q + CNT_W'(1) : flush_q;
    end
  end
endmodule

// File: doc/pipe_hazard_ctrl.md
# pipe_hazard_ctrl

Pipeline hazard and sequencing controller for the 5-stage 32-bit RISC pipeline. It drives the `hazard` hold input of the PC controller. It also drives the hold, flush and bubble controls of the IF/ID, ID/EX and EX/MEM pipeline registers. It resolves load-use RAW hazards, taken branches and jumps, and data-memory wait states, and keeps saturating stall and flush counters for performance analysis.

## Interface
Parameters:
- `REG_AW`, 5: register-address width.
- `LOAD_LAT`, 1: total stall cycles inserted per load-use hazard (1..15).
- `CNT_W`, 16: width of the performance counters.

Ports:
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  reset, synchronous, active-low.
- `id_valid`  in  1  ID stage holds a real instruction.
- `id_rs`, `id_rt`  in  REG_AW  ID source registers.
- `id_uses_rs`, `id_uses_rt`  in  1  ID instruction reads rs / rt.
- `id_jump`  in  1  ID instruction is a jump.
- `ex_valid`  in  1  EX stage holds a real instruction.
- `ex_rd`  in  REG_AW  EX destination register.
- `ex_mem_read`  in  1  EX instruction is a load.
- `branch_taken`  in  1  EX branch resolved taken (branch & zero_flag).
- `mem_busy`  in  1  data memory not ready this cycle.
- `hazard`  out  1  PC hold; the PC keeps its value when 1.
- `ifid_hold`  out  1  IF/ID register keeps its value.
- `ifid_flush`  out  1  IF/ID register loads a NOP.
- `idex_bubble`  out  1  ID/EX register loads a NOP.
- `idex_hold`, `exmem_hold`  out  1  freeze ID/EX, EX/MEM.
- `stall_cycles`  out  CNT_W  count of cycles with `hazard`=1.
- `flush_count`  out  CNT_W  count of cycles with `ifid_flush`=1.

## Operation
- States: RUN, LSTALL, FREEZE. Outputs are Mealy: they are combinational from the state, `cnt` and the current inputs.
- Load-use detect: `lu = ex_valid & ex_mem_read & (ex_rd != 0) & id_valid & ((id_uses_rs & id_rs==ex_rd) | (id_uses_rt & id_rt==ex_rd))`.
- Priority, evaluated every cycle: mem_busy > branch_taken > load-use/LSTALL > id_jump > normal.
- mem_busy=1 asserts `hazard`, `ifid_hold`, `idex_hold` and `exmem_hold`. The next state is FREEZE, and the prior state and `cnt` are preserved in `ret_state`.
- FREEZE with mem_busy=0 returns to `ret_state` in the next cycle. The outputs in that cycle follow `ret_state`.
- branch_taken (mem_busy=0) asserts `ifid_flush` and `idex_bubble`, with `hazard`=0 so the PC loads the target. It cancels any LSTALL: the next state is RUN and `cnt` is set to 0.
- Load-use in RUN asserts `hazard`, `ifid_hold` and `idex_bubble`.
  - If LOAD_LAT>1, the next state is LSTALL and `cnt` is set to LOAD_LAT-1.
  - Otherwise the state stays RUN.
- LSTALL asserts the same three outputs, regardless of `lu`, and decrements `cnt`. It returns to RUN when `cnt` reaches 0 after the decrement.
- `id_jump` with no higher-priority event asserts `ifid_flush` only.
- `ex_rd`=0 never causes a stall.
- Counters increment by 1 in any cycle where the corresponding output is 1. They saturate at all-ones and never wrap.

## Timing
- Zero-latency outputs: an input change affects outputs in the same cycle, before the edge at which the PC and pipeline registers sample them.
- A load-use hazard costs exactly LOAD_LAT cycles of `hazard`=1.
- A taken branch costs 2 flushed slots in one cycle. A jump costs 1 slot.
- Reset (rst=0 at an edge) takes effect from any state, including mid-LSTALL or mid-FREEZE:
  - state=RUN, `cnt`=0, `ret_state`=RUN, both counters 0.
  - While rst=0, all control outputs are forced to 0.
- mem_busy held for N cycles adds exactly N cycles to any stall in progress. `cnt` does not decrement during FREEZE.
- Counters are updated on the edge that ends the cycle being counted, so they are visible in the following cycle.

## Structure
- Package `pipe_ctrl_pkg` holds:
  - the state enum (RUN=2'd0, LSTALL=2'd1, FREEZE=2'd2);
  - the constant `REG_ZERO`;
  - the default `CNT_W`.
- Sub-module `raw_detect`: a purely combinational `lu` comparator. It is reused by a future forwarding unit.
- The top level contains the FSM, the `cnt`/`ret_state` registers, the output decode and the two saturating counters.

## Test plan
- Load-use: `ex_mem_read`=1, `ex_rd`=5, `id_rs`=5, `id_uses_rs`=1, LOAD_LAT=1. Required: `hazard`, `ifid_hold` and `idex_bubble` are 1 for exactly 1 cycle, and `stall_cycles`=1 afterward.
- LOAD_LAT=3, same stimulus. Required: 3 consecutive stall cycles, then RUN. With `ex_rd`=0 instead, no stall occurs.
- branch_taken pulse during the second LSTALL cycle. Required: that cycle shows `ifid_flush`=1, `idex_bubble`=1 and `hazard`=0. The next cycle is RUN with no stall, and `flush_count` increments by 1.
- mem_busy held for 4 cycles during LSTALL (LOAD_LAT=3, `cnt`=1). Required: all holds are 1 for 4 cycles, then 1 remaining stall cycle, then RUN. `stall_cycles` increases by 5.
- `id_jump`=1 with mem_busy=1 in the same cycle. Required: freeze only, with `ifid_flush`=0. In the next cycle, with mem_busy=0, `ifid_flush`=1.
- Force counters near 0xFFFE, then run 5 stall cycles. Required: `stall_cycles` saturates at 0xFFFF. Assert rst=0 mid-stall: the next cycle shows all outputs 0 and the counters cleared.
